// File: rtl/glitch_pkg.sv
// Shared types for the glitch result reader: FSM states, default header bytes,
// the FIFO entry layout and a saturating increment helper.
package glitch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  localparam logic [7:0] HDR_OK_DEF    = 8'hA5;
  localparam logic [7:0] HDR_FAULT_DEF = 8'hE5;

  typedef struct packed {
    logic       fault;
    logic [7:0] data;
  } entry_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/result_reader_if.sv
// Result capture and transmit-side bundle of the result reader; the reader
// takes the slave view, the producer/transmitter side takes the master view.
interface result_reader_if;

  logic [7:0] finout;
  logic       DV_3;
  logic [7:0] expected;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] fault_cnt;
  logic       overflow;
  logic       busy;

  modport slave (
    input  finout, DV_3, expected, tx_ready,
    output tx_data, tx_valid, fault_cnt, overflow, busy
  );

  modport master (
    output finout, DV_3, expected, tx_ready,
    input  tx_data, tx_valid, fault_cnt, overflow, busy
  );

endinterface

// File: rtl/result_fifo.sv
// Small power-of-two result FIFO with a combinational head-fault peek and a
// registered read port that loads the popped entry's data byte.
module result_fifo
  import glitch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        glitched_clk,
  input  logic        rst,
  input  logic        i_push,
  input  entry_t      i_din,
  input  logic        i_pop,
  output logic        o_head_fault,
  output logic [7:0]  o_q_data,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [7:0]      r_q_data;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_full       = (r_count == (AW+1)'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign w_pop_ok     = i_pop && !o_empty;
  // A full FIFO still takes a push when the same edge frees a slot.
  assign w_push_ok    = i_push && (!o_full || w_pop_ok);
  assign o_head_fault = r_mem[r_rd_ptr].fault;
  assign o_q_data     = r_q_data;
  assign o_count      = r_count;

  // NOTE: the storage array is deliberately left without reset; pointers and
  // count alone define which entries are valid, so it maps onto plain RAM.
  always_ff @(posedge glitched_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge glitched_clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_q_data <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_q_data <= r_mem[r_rd_ptr].data;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/result_reader.sv
// Captures pipeline results, flags mismatches against the golden byte and
// streams each one out as a header byte followed by the result byte.
module result_reader
  import glitch_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] HDR_OK    = HDR_OK_DEF,
  parameter logic [7:0] HDR_FAULT = HDR_FAULT_DEF
) (
  input  logic            glitched_clk,
  input  logic            rst,
  result_reader_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  state_t      r_state;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [7:0]  r_fault_cnt;
  logic        r_overflow;

  logic        w_fault;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_head_fault;
  logic [7:0]  w_q_data;
  logic [AW:0] w_count;
  entry_t      w_din;

  assign w_fault = (bus.finout != bus.expected);
  assign w_din   = '{fault: w_fault, data: bus.finout};
  // Pop when leaving IDLE or when a DATA byte is accepted, so the next header
  // is launched on the same edge with no bubble.
  assign w_pop   = !w_empty &&
                   ((r_state == IDLE) || ((r_state == DATA) && bus.tx_ready));

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .glitched_clk (glitched_clk),
    .rst          (rst),
    .i_push       (bus.DV_3),
    .i_din        (w_din),
    .i_pop        (w_pop),
    .o_head_fault (w_head_fault),
    .o_q_data     (w_q_data),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

  function automatic logic [7:0] hdr_byte(input logic fault);
    return fault ? HDR_FAULT : HDR_OK;
  endfunction

  always_ff @(posedge glitched_clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_fault_cnt <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      if (bus.DV_3 && w_fault) r_fault_cnt <= sat_inc(r_fault_cnt);
      if (bus.DV_3 && w_full && !w_pop) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state    <= HDR;
            r_tx_valid <= 1'b1;
            r_tx_data  <= hdr_byte(w_head_fault);
          end
        end
        HDR: begin
          if (bus.tx_ready) begin
            r_state   <= DATA;
            r_tx_data <= w_q_data;
          end
        end
        DATA: begin
          if (bus.tx_ready) begin
            if (!w_empty) begin
              r_state   <= HDR;
              r_tx_data <= hdr_byte(w_head_fault);
            end else begin
              r_state    <= IDLE;
              r_tx_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.fault_cnt = r_fault_cnt;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_result_reader.sv
// Self-checking bench for result_reader: directed scenarios plus randomized
// bursts, compared against a packet-stream and fault-count model.
module tb_result_reader;
  import glitch_pkg::*;

  logic glitched_clk = 1'b0;
  logic rst          = 1'b0;

  int total     = 0;
  int bad       = 0;
  int fcnt      = 0;
  int cyc       = 0;
  int stall_err = 0;
  int gap;
  bit stalled   = 1'b0;
  logic [7:0] stall_data;
  logic [7:0] v;
  int         n;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_cyc[$];

  result_reader_if bus();

  result_reader #(.DEPTH(4), .HDR_OK(8'hA5), .HDR_FAULT(8'hE5)) dut (
    .glitched_clk (glitched_clk),
    .rst          (rst),
    .bus          (bus)
  );

  always #5 glitched_clk = ~glitched_clk;

  always @(posedge glitched_clk) cyc <= cyc + 1;

  // Handshake monitor: a byte counts as sent when valid and ready are both
  // seen mid-cycle ahead of a non-reset edge; stalled bytes must not change.
  always @(negedge glitched_clk) begin
    if (rst && bus.tx_valid) begin
      if (stalled && (bus.tx_data !== stall_data)) stall_err++;
      if (bus.tx_ready) begin
        rx_q.push_back(bus.tx_data);
        rx_cyc.push_back(cyc);
        stalled = 1'b0;
      end else begin
        stalled    = 1'b1;
        stall_data = bus.tx_data;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge glitched_clk);
    #1;
  endtask

  function automatic logic [31:0] sat_cnt();
    return (fcnt > 255) ? 32'd255 : 32'(fcnt);
  endfunction

  task automatic push_result(input logic [7:0] val, input bit track, input bit rnd);
    bit f;
    f = (val != bus.expected);
    bus.finout = val;
    bus.DV_3   = 1'b1;
    if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
    next_cycle();
    bus.DV_3 = 1'b0;
    if (f) fcnt++;
    if (track) begin
      exp_q.push_back(f ? 8'hE5 : 8'hA5);
      exp_q.push_back(val);
    end
  endtask

  task automatic wait_idle(input bit rnd, input int budget);
    int k;
    k = 0;
    @(negedge glitched_clk);
    while ((bus.busy || bus.tx_valid) && k < budget) begin
      next_cycle();
      if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
      k++;
      @(negedge glitched_clk);
    end
    check("idle_in_budget", 32'(k < budget), 32'd1);
    next_cycle();
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
    exp_q.delete();
    rx_q.delete();
    rx_cyc.delete();
  endtask

  initial begin
    bus.finout   = 8'h00;
    bus.DV_3     = 1'b0;
    bus.expected = 8'h00;
    bus.tx_ready = 1'b0;
    rst          = 1'b0;
    repeat (3) next_cycle();
    @(negedge glitched_clk);
    check("rst_tx_valid",  bus.tx_valid,  0);
    check("rst_tx_data",   bus.tx_data,   8'h00);
    check("rst_fault_cnt", bus.fault_cnt, 8'h00);
    check("rst_overflow",  bus.overflow,  0);
    check("rst_busy",      bus.busy,      0);
    next_cycle();
    rst = 1'b1;

    // Matching result: header A5, two-edge latency from capture.
    bus.expected = 8'h3C;
    bus.tx_ready = 1'b1;
    next_cycle();
    push_result(8'h3C, 1, 0);
    @(negedge glitched_clk);
    check("lat_not_yet", bus.tx_valid, 0);
    @(negedge glitched_clk);
    check("lat_valid", bus.tx_valid, 1);
    check("lat_hdr",   bus.tx_data,  8'hA5);
    wait_idle(0, 20);
    compare_stream("ok_pkt");
    check("ok_fault_cnt", bus.fault_cnt, sat_cnt());
    check("ok_busy_low",  bus.busy, 0);

    // Mismatching result: header E5.
    push_result(8'h3D, 1, 0);
    wait_idle(0, 20);
    compare_stream("fault_pkt");
    check("fault_cnt_1", bus.fault_cnt, sat_cnt());

    // Stalled transmitter, six results into a four-deep FIFO.
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_result(8'(i), i <= 5, 0);
    @(negedge glitched_clk);
    check("ovf_flag",     bus.overflow, 1);
    check("ovf_valid",    bus.tx_valid, 1);
    check("ovf_hold_hdr", bus.tx_data,  8'hE5);
    next_cycle();
    bus.tx_ready = 1'b1;
    wait_idle(0, 40);
    gap = rx_cyc[rx_cyc.size()-1] - rx_cyc[0];
    check("ovf_no_gap", gap, 9);
    compare_stream("ovf");
    check("ovf_fault_cnt", bus.fault_cnt, sat_cnt());
    check("ovf_sticky",    bus.overflow, 1);

    // Ready toggling every cycle during packets.
    bus.tx_ready = 1'b0;
    push_result(8'h77, 1, 0);
    push_result(8'h3C, 1, 0);
    for (int i = 0; i < 16; i++) begin
      bus.tx_ready = ~bus.tx_ready;
      next_cycle();
    end
    bus.tx_ready = 1'b1;
    wait_idle(0, 40);
    check("toggle_stable", stall_err, 0);
    compare_stream("toggle");

    // Randomized bursts that never exceed capacity, random backpressure.
    for (int b = 0; b < 20; b++) begin
      bus.expected = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        v = ($urandom_range(0, 1) == 1) ? bus.expected : 8'($urandom);
        push_result(v, 1, 1);
      end
      wait_idle(1, 200);
    end
    compare_stream("rand");
    check("rand_stable",    stall_err, 0);
    check("rand_fault_cnt", bus.fault_cnt, sat_cnt());

    // 300 mismatches saturate the fault counter.
    bus.tx_ready = 1'b1;
    bus.expected = 8'h00;
    for (int i = 0; i < 300; i++) push_result(8'(i % 255 + 1), 0, 0);
    wait_idle(0, 100);
    rx_q.delete();
    rx_cyc.delete();
    check("fault_sat", bus.fault_cnt, sat_cnt());

    // Reset while the data byte of a packet is pending.
    bus.expected = 8'h3C;
    bus.tx_ready = 1'b0;
    push_result(8'h55, 0, 0);
    next_cycle();
    bus.tx_ready = 1'b1;
    next_cycle();
    bus.tx_ready = 1'b0;
    @(negedge glitched_clk);
    check("pre_rst_valid", bus.tx_valid, 1);
    check("pre_rst_data",  bus.tx_data,  8'h55);
    next_cycle();
    rst        = 1'b0;
    bus.DV_3   = 1'b1;
    bus.finout = 8'h99;
    next_cycle();
    bus.DV_3 = 1'b0;
    rst      = 1'b1;
    @(negedge glitched_clk);
    check("mid_rst_valid",     bus.tx_valid,  0);
    check("mid_rst_busy",      bus.busy,      0);
    check("mid_rst_fault_cnt", bus.fault_cnt, 8'h00);
    check("mid_rst_overflow",  bus.overflow,  0);
    check("mid_rst_tx_data",   bus.tx_data,   8'h00);
    fcnt = 0;
    exp_q.delete();
    rx_q.delete();
    rx_cyc.delete();
    next_cycle();
    bus.tx_ready = 1'b1;
    push_result(8'h3C, 1, 0);
    push_result(8'h3B, 1, 0);
    wait_idle(0, 40);
    compare_stream("post_rst");
    check("post_rst_fault_cnt", bus.fault_cnt, sat_cnt());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, meaning result FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL expose parameter HDR_OK, default 8'hA5, meaning header byte for a result matching expected.
REQ-003 The block SHALL expose parameter HDR_FAULT, default 8'hE5, meaning header byte for a mismatching (glitched) result.
REQ-004 glitched_clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 finout  in  8  result byte from the second pipeline stage.
REQ-007 DV_3  in  1  finout valid qualifier; one result per high cycle.
REQ-008 expected  in  8  golden result; quasi-static, sampled with each capture.
REQ-009 tx_data  out  8  byte toward serial transmitter.
REQ-010 tx_valid  out  1  tx_data valid.
REQ-011 tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready.
REQ-012 fault_cnt  out  8  saturating count of mismatching results.
REQ-013 overflow  out  1  sticky; a result was dropped on full FIFO.
REQ-014 busy  out  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-015 On a cycle with DV_3=1, the block SHALL compute fault = (finout != expected) and push {fault, finout} into the FIFO at that edge.
REQ-016 Push on a full FIFO SHALL be accepted only if a pop occurs the same cycle; otherwise the result is dropped and overflow set to 1 until reset.
REQ-017 fault_cnt SHALL increment by 1 for every DV_3 cycle with fault=1, dropped or not, saturating at 8'hFF.
REQ-018 FSM states SHALL be IDLE, HDR, DATA.
REQ-019 IDLE: if FIFO non-empty, pop into a holding register and go to HDR; else stay.
REQ-020 HDR: tx_valid=1, tx_data = held fault ? HDR_FAULT : HDR_OK; on tx_ready go DATA.
REQ-021 DATA: tx_valid=1, tx_data = held result byte; on tx_ready, pop next entry and go HDR if FIFO non-empty, else go IDLE.
REQ-022 tx_valid SHALL be registered and 0 in IDLE; tx_data SHALL remain stable while tx_valid && !tx_ready.
REQ-023 Latency: DV_3 at edge N into empty idle block SHALL give tx_valid=1 with header from edge N+2.
REQ-024 Back-to-back packets SHALL have no idle cycle between a DATA accept and the next HDR when FIFO is non-empty.
REQ-025 Results SHALL be emitted in arrival order; no result emitted twice.
REQ-026 tx_ready while tx_valid=0 SHALL be ignored.

Reset
REQ-027 With rst=0 at an edge, FSM SHALL go to IDLE, FIFO pointers and count to 0, tx_valid=0, tx_data=8'h00, fault_cnt=0, overflow=0, busy=0.
REQ-028 Reset mid-packet SHALL abandon the packet; tx_valid low the cycle after the reset edge; DV_3 during reset ignored.

Structure
REQ-029 Package glitch_pkg SHALL hold the FSM state enum, HDR_OK/HDR_FAULT defaults and the FIFO entry struct {fault, data[7:0]}.
REQ-030 FIFO SHALL be a sub-module result_fifo (push, pop, full, empty, count, synchronous read into holding register).
REQ-031 FSM, fault comparison and counters SHALL live in result_reader.

Verification
REQ-032 expected=8'h3C, DV_3 one cycle with finout=8'h3C, tx_ready=1 -> bytes A5,3C; fault_cnt=0; busy low after DATA accept.
REQ-033 expected=8'h3C, finout=8'h3D -> bytes E5,3D; fault_cnt=1.
REQ-034 tx_ready=0, six consecutive DV_3 results 01..06 (DEPTH=4) -> overflow=1; after tx_ready=1, exactly the held result plus four FIFO entries emitted in order, each as header+data, no gaps.
REQ-035 tx_ready toggling 1/0 each cycle during a packet -> tx_data stable while stalled; byte sequence unchanged.
REQ-036 300 mismatching results with tx_ready=1 -> fault_cnt saturates at FF.
REQ-037 rst=0 asserted while in DATA -> next cycle tx_valid=0, busy=0, counters 0; subsequent result emits normal A5/E5 packet.
